// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared MDU opcode encodings, default latencies and op width,
// reused by the E-stage MDU, the D-stage controller and the hazard unit.
package e_mdu_pkg;

    localparam int MDU_OP_W        = 3;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/e_mdu_calc.sv
// mdu_calc: combinational mult/div datapath for the E-stage MDU.
// Ports: op (MDU opcode), a/b (operands) -> hi/lo (64-bit result),
//        div_by_zero (div/divu with b == 0).
module mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    output logic                div_by_zero
);

    logic signed [63:0] sa, sb, ms;
    logic [63:0] mu;
    logic [31:0] ma, mb, bd, q, r, qs, rs;
    logic sgn;

    always_comb begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ms = sa * sb;
        mu = {32'b0, a} * {32'b0, b};
        sgn = op == MDU_DIV;
        // Signed division runs on magnitudes; 0x80000000 / -1 then yields
        // magnitude 0x80000000, whose negation wraps back to 0x80000000.
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        div_by_zero = (op == MDU_DIV || op == MDU_DIVU) && b == 32'd0;
        // Substitute a safe divisor; the result is discarded downstream.
        bd = (mb == 32'd0) ? 32'd1 : mb;
        q = ma / bd;
        r = ma % bd;
        qs = (sgn && (a[31] ^ b[31])) ? -q : q;
        rs = (sgn && a[31]) ? -r : r;
        {hi, lo} = (op == MDU_MULT)  ? ms :
                   (op == MDU_MULTU) ? mu :
                   (op == MDU_DIV || op == MDU_DIVU) ? {rs, qs} : 64'd0;
    end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO with fixed-latency busy.
// Ports: clk, reset (async active-low), E_MDU_op, E_MDU_start (launch pulse),
//        E_GRF_RD1/E_GRF_RD2 (operands), E_MDU_busy, E_HI, E_LO (registered).
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MDU_OP_W-1:0] E_MDU_op,
    input  logic                E_MDU_start,
    input  logic [31:0]         E_GRF_RD1,
    input  logic [31:0]         E_GRF_RD2,
    output logic                E_MDU_busy,
    output logic [31:0]         E_HI,
    output logic [31:0]         E_LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] pend_hi, pend_lo, pend_hi_n, pend_lo_n, hi_n, lo_n, c_hi, c_lo;
    logic pend_ok, pend_ok_n, dbz, launch, is_mul;
    mdu_state_e state;

    mdu_calc u_calc (
        .op          (E_MDU_op),
        .a           (E_GRF_RD1),
        .b           (E_GRF_RD2),
        .hi          (c_hi),
        .lo          (c_lo),
        .div_by_zero (dbz)
    );

    assign state      = (cnt != '0) ? BUSY : IDLE;
    assign E_MDU_busy = state == BUSY;
    assign launch     = E_MDU_start && E_MDU_op >= MDU_MULT && E_MDU_op <= MDU_DIVU;
    assign is_mul     = E_MDU_op == MDU_MULT || E_MDU_op == MDU_MULTU;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
            E_HI    <= '0;
            E_LO    <= '0;
        end else begin
            cnt     <= cnt_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_ok <= pend_ok_n;
            E_HI    <= hi_n;
            E_LO    <= lo_n;
        end
    end

    always_comb begin
        cnt_n     = cnt;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_ok_n = pend_ok;
        hi_n      = E_HI;
        lo_n      = E_LO;
        if (state == IDLE) begin
            if (launch) begin
                pend_hi_n = c_hi;
                pend_lo_n = c_lo;
                // A zero divisor still occupies the full busy period.
                pend_ok_n = !dbz;
                cnt_n     = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (!E_MDU_start) begin
                hi_n = (E_MDU_op == MDU_MTHI) ? E_GRF_RD1 : E_HI;
                lo_n = (E_MDU_op == MDU_MTLO) ? E_GRF_RD1 : E_LO;
            end
        end else begin
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1) && pend_ok) begin
                hi_n = pend_hi;
                lo_n = pend_lo;
            end
        end
    end

endmodule
